// File: rtl/vga_ctrl_pkg.sv
// Shared constants and FSM encoding for the board update path.
// Timing values describe the 800x521 frame of the VGA generator.
package vga_ctrl_pkg;

    localparam int NUM_WIDTH = 4;
    localparam int HPIXELS   = 800;
    localparam int VLINES    = 521;
    localparam int VBP       = 31;
    localparam int VFP       = 511;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } board_fsm_e;

endpackage

// File: rtl/tile_diff.sv
// Per-tile inequality of two 16-tile boards.
// Bit i of diff is set when tile i differs between a and b.
module tile_diff #(
    parameter int NUM_WIDTH = vga_ctrl_pkg::NUM_WIDTH
) (
    input  logic [0:NUM_WIDTH*16-1] a,
    input  logic [0:NUM_WIDTH*16-1] b,
    output logic [0:15]             diff
);

    // Compare every tile slot independently.
    always_comb begin
        diff = '0;
        for (int i = 0; i < 16; i++) begin
            diff[i] = a[i*NUM_WIDTH +: NUM_WIDTH] != b[i*NUM_WIDTH +: NUM_WIDTH];
        end
    end

endmodule

// File: rtl/board_update_ctrl.sv
// Frame-synchronous board update controller: accepts a board, commits at blanking.
// Optional changed-tile highlight is built when BOARD_HIGHLIGHT_EN is defined.
module board_update_ctrl #(
    parameter int NUM_WIDTH = vga_ctrl_pkg::NUM_WIDTH,
    parameter int HPIXELS   = vga_ctrl_pkg::HPIXELS,
    parameter int VFP       = vga_ctrl_pkg::VFP,
    parameter int HL_FRAMES = 8
) (
    input  logic                    dclk,
    input  logic                    clr,
    input  logic [9:0]              hc,
    input  logic [9:0]              vc,
    input  logic                    upd_valid,
    input  logic [0:NUM_WIDTH*16-1] upd_state,
    output logic                    upd_ready,
    output logic [0:NUM_WIDTH*16-1] disp_state,
    output logic                    commit_pulse,
    output logic [7:0]              frame_cnt,
    output logic [0:15]             highlight_mask
);
    import vga_ctrl_pkg::*;

    // An inconsistent timing setup never produces a blanking strobe.
    localparam bit CFG_OK = (VFP > VBP) && (VFP < VLINES) &&
                            (HPIXELS > 0) && (HL_FRAMES > 0);

    board_fsm_e state;
    board_fsm_e state_nx;

    logic                    blank_start;
    logic                    xfer;
    logic                    do_commit;
    logic [0:NUM_WIDTH*16-1] shadow;

    assign blank_start = CFG_OK && (vc == 10'(VFP)) && (hc == 10'd0);

    // State register.
    always_ff @(posedge dclk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: accept in IDLE, wait for blanking, single commit cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (xfer)        state_nx = PENDING;
            PENDING: if (blank_start) state_nx = COMMIT;
            COMMIT:                   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // Handshake and commit strobes decoded from the current state.
    always_comb begin
        upd_ready = (state == IDLE) && !clr;
        xfer      = upd_valid && upd_ready;
        do_commit = (state == PENDING) && blank_start;
    end

    // Shadow capture, display commit and frame counting.
    always_ff @(posedge dclk) begin
        if (clr) begin
            shadow       <= '0;
            disp_state   <= '0;
            commit_pulse <= 1'b0;
            frame_cnt    <= 8'd0;
        end else begin
            commit_pulse <= do_commit;
            if (xfer)        shadow     <= upd_state;
            if (do_commit)   disp_state <= shadow;
            if (blank_start) frame_cnt  <= frame_cnt + 8'd1;
        end
    end

`ifdef BOARD_HIGHLIGHT_EN
    localparam int HLW = $clog2(HL_FRAMES + 1);

    logic [0:15]    diff;
    logic [0:15]    hl_mask;
    logic [HLW-1:0] hl_cnt;

    tile_diff #(
        .NUM_WIDTH(NUM_WIDTH)
    ) u_diff (
        .a   (shadow),
        .b   (disp_state),
        .diff(diff)
    );

    // Capture changed tiles on commit and age them out over blanking strobes.
    always_ff @(posedge dclk) begin
        if (clr) begin
            hl_mask <= '0;
            hl_cnt  <= '0;
        end else if (do_commit) begin
            hl_mask <= diff;
            hl_cnt  <= HLW'(HL_FRAMES);
        end else if (blank_start && hl_cnt != '0) begin
            hl_cnt <= hl_cnt - HLW'(1);
            if (hl_cnt == HLW'(1)) hl_mask <= '0;
        end
    end

    assign highlight_mask = hl_mask;
`else
    assign highlight_mask = '0;
`endif

endmodule

// File: tb/tb_board_update_ctrl.sv
// Directed bench for board_update_ctrl.
// Drives hc/vc directly so each frame is a single blanking strobe.
module tb_board_update_ctrl;

    localparam int W  = 4;
    localparam int BW = W * 16;

    logic          dclk = 1'b0;
    logic          clr;
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          upd_valid;
    logic [0:BW-1] upd_state;
    logic          upd_ready;
    logic [0:BW-1] disp_state;
    logic          commit_pulse;
    logic [7:0]    frame_cnt;
    logic [0:15]   highlight_mask;

    int       n_pass = 0;
    int       n_tot  = 0;
    logic [7:0] exp_fc = 8'd0;

    board_update_ctrl #(
        .NUM_WIDTH(W),
        .HPIXELS  (800),
        .VFP      (511),
        .HL_FRAMES(8)
    ) dut (
        .dclk          (dclk),
        .clr           (clr),
        .hc            (hc),
        .vc            (vc),
        .upd_valid     (upd_valid),
        .upd_state     (upd_state),
        .upd_ready     (upd_ready),
        .disp_state    (disp_state),
        .commit_pulse  (commit_pulse),
        .frame_cnt     (frame_cnt),
        .highlight_mask(highlight_mask)
    );

    always #5 dclk = ~dclk;

    function automatic logic [0:BW-1] put(input logic [0:BW-1] b,
                                          input int idx,
                                          input logic [W-1:0] v);
        logic [0:BW-1] r;
        r = b;
        r[idx*W +: W] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    task automatic blank();
        vc = 10'd511;
        hc = 10'd0;
        step();
        vc = 10'd100;
        hc = 10'd1;
        exp_fc = exp_fc + 8'd1;
    endtask

    task automatic xfer(input logic [0:BW-1] b);
        upd_state = b;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        upd_valid = 1'b0;
        upd_state = '0;
        hc = 10'd1;
        vc = 10'd100;
        step();
        step();
        n_tot++;
        if (upd_ready !== 1'b0) $display("FAIL rst_ready_in_clr got %b exp 0", upd_ready);
        else n_pass++;
        clr = 1'b0;
        #1;
        exp_fc = 8'd0;
        n_tot++;
        if (upd_ready !== 1'b1 || disp_state !== '0 || commit_pulse !== 1'b0 ||
            frame_cnt !== 8'd0 || highlight_mask !== '0)
            $display("FAIL rst_state got rdy=%b disp=%h cp=%b fc=%0d hm=%h exp 1/0/0/0/0",
                     upd_ready, disp_state, commit_pulse, frame_cnt, highlight_mask);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [0:BW-1] b1;
        b1 = put('0, 0, 4'd1);
        xfer(b1);
        n_tot++;
        if (upd_ready !== 1'b0) $display("FAIL basic_ready_drop got %b exp 0", upd_ready);
        else n_pass++;
        repeat (3) step();
        n_tot++;
        if (disp_state !== '0 || commit_pulse !== 1'b0)
            $display("FAIL basic_early got disp=%h cp=%b exp 0/0", disp_state, commit_pulse);
        else n_pass++;
        blank();
        n_tot++;
        if (disp_state !== b1 || commit_pulse !== 1'b1 || frame_cnt !== exp_fc)
            $display("FAIL basic_commit got disp=%h cp=%b fc=%0d exp %h/1/%0d",
                     disp_state, commit_pulse, frame_cnt, b1, exp_fc);
        else n_pass++;
        step();
        n_tot++;
        if (commit_pulse !== 1'b0 || upd_ready !== 1'b1 || disp_state !== b1)
            $display("FAIL basic_after got cp=%b rdy=%b disp=%h exp 0/1/%h",
                     commit_pulse, upd_ready, disp_state, b1);
        else n_pass++;
    endtask

    task automatic test_busy();
        logic [0:BW-1] p;
        logic [0:BW-1] q;
        p = put(disp_state, 1, 4'd4);
        q = put(disp_state, 5, 4'd3);
        xfer(p);
        upd_state = q;
        upd_valid = 1'b1;
        step();
        step();
        n_tot++;
        if (upd_ready !== 1'b0) $display("FAIL busy_ready got %b exp 0", upd_ready);
        else n_pass++;
        blank();
        n_tot++;
        if (disp_state !== p || commit_pulse !== 1'b1)
            $display("FAIL busy_first got disp=%h cp=%b exp %h/1", disp_state, commit_pulse, p);
        else n_pass++;
        step();
        n_tot++;
        if (upd_ready !== 1'b1) $display("FAIL busy_reaccept got %b exp 1", upd_ready);
        else n_pass++;
        step();
        upd_valid = 1'b0;
        n_tot++;
        if (upd_ready !== 1'b0 || disp_state !== p)
            $display("FAIL busy_pend got rdy=%b disp=%h exp 0/%h", upd_ready, disp_state, p);
        else n_pass++;
        blank();
        n_tot++;
        if (disp_state !== q || commit_pulse !== 1'b1)
            $display("FAIL busy_second got disp=%h cp=%b exp %h/1", disp_state, commit_pulse, q);
        else n_pass++;
        step();
    endtask

    task automatic test_boundary();
        logic [0:BW-1] q;
        logic [0:BW-1] r;
        q = disp_state;
        r = put(q, 15, 4'd9);
        vc = 10'd511;
        hc = 10'd0;
        upd_state = r;
        upd_valid = 1'b1;
        step();
        exp_fc = exp_fc + 8'd1;
        upd_valid = 1'b0;
        vc = 10'd100;
        hc = 10'd1;
        n_tot++;
        if (upd_ready !== 1'b0 || commit_pulse !== 1'b0 || disp_state !== q ||
            frame_cnt !== exp_fc)
            $display("FAIL bound_xfer got rdy=%b cp=%b disp=%h fc=%0d exp 0/0/%h/%0d",
                     upd_ready, commit_pulse, disp_state, frame_cnt, q, exp_fc);
        else n_pass++;
        repeat (5) step();
        n_tot++;
        if (disp_state !== q || commit_pulse !== 1'b0)
            $display("FAIL bound_hold got disp=%h cp=%b exp %h/0", disp_state, commit_pulse, q);
        else n_pass++;
        blank();
        n_tot++;
        if (disp_state !== r || commit_pulse !== 1'b1)
            $display("FAIL bound_commit got disp=%h cp=%b exp %h/1", disp_state, commit_pulse, r);
        else n_pass++;
        step();
    endtask

    task automatic test_wrap();
        vc = 10'd511;
        for (int i = 1; i < 4; i++) begin
            hc = 10'(i);
            step();
        end
        vc = 10'd100;
        hc = 10'd1;
        n_tot++;
        if (frame_cnt !== exp_fc)
            $display("FAIL wrap_hc_nonzero got %0d exp %0d", frame_cnt, exp_fc);
        else n_pass++;
        while (exp_fc != 8'd255) blank();
        n_tot++;
        if (frame_cnt !== 8'd255) $display("FAIL wrap_255 got %0d exp 255", frame_cnt);
        else n_pass++;
        blank();
        n_tot++;
        if (frame_cnt !== 8'd0 || exp_fc !== 8'd0)
            $display("FAIL wrap_0 got %0d exp 0", frame_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        xfer(put('0, 3, 4'd7));
        step();
        clr = 1'b1;
        step();
        vc = 10'd511;
        hc = 10'd0;
        step();
        vc = 10'd100;
        hc = 10'd1;
        clr = 1'b0;
        #1;
        exp_fc = 8'd0;
        n_tot++;
        if (upd_ready !== 1'b1 || disp_state !== '0 || commit_pulse !== 1'b0 ||
            frame_cnt !== 8'd0 || highlight_mask !== '0)
            $display("FAIL rstmid_state got rdy=%b disp=%h cp=%b fc=%0d hm=%h exp 1/0/0/0/0",
                     upd_ready, disp_state, commit_pulse, frame_cnt, highlight_mask);
        else n_pass++;
        blank();
        n_tot++;
        if (commit_pulse !== 1'b0 || disp_state !== '0 || frame_cnt !== exp_fc)
            $display("FAIL rstmid_discard got cp=%b disp=%h fc=%0d exp 0/0/%0d",
                     commit_pulse, disp_state, frame_cnt, exp_fc);
        else n_pass++;
        xfer(put('0, 4, 4'd2));
        blank();
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        exp_fc = 8'd0;
        n_tot++;
        if (commit_pulse !== 1'b0 || disp_state !== '0 || upd_ready !== 1'b1)
            $display("FAIL rstcommit got cp=%b disp=%h rdy=%b exp 0/0/1",
                     commit_pulse, disp_state, upd_ready);
        else n_pass++;
    endtask

    task automatic test_highlight();
        logic [0:BW-1] a;
        logic [0:15]   m27;
        logic [0:15]   m9;
        a = put(put('0, 2, 4'd5), 7, 4'd1);
        m27 = '0;
        m9  = '0;
`ifdef BOARD_HIGHLIGHT_EN
        m27[2] = 1'b1;
        m27[7] = 1'b1;
        m9[9]  = 1'b1;
`endif
        xfer(a);
        blank();
        n_tot++;
        if (highlight_mask !== m27 || disp_state !== a)
            $display("FAIL hl_set got hm=%h disp=%h exp %h/%h", highlight_mask, disp_state, m27, a);
        else n_pass++;
        repeat (7) blank();
        n_tot++;
        if (highlight_mask !== m27) $display("FAIL hl_hold7 got %h exp %h", highlight_mask, m27);
        else n_pass++;
        blank();
        n_tot++;
        if (highlight_mask !== '0) $display("FAIL hl_clear8 got %h exp 0", highlight_mask);
        else n_pass++;
        xfer('0);
        blank();
        repeat (3) blank();
        n_tot++;
        if (highlight_mask !== m27) $display("FAIL hl_recommit_pre got %h exp %h", highlight_mask, m27);
        else n_pass++;
        xfer(put('0, 9, 4'd6));
        blank();
        n_tot++;
        if (highlight_mask !== m9) $display("FAIL hl_replace got %h exp %h", highlight_mask, m9);
        else n_pass++;
        repeat (7) blank();
        n_tot++;
        if (highlight_mask !== m9) $display("FAIL hl_reload got %h exp %h", highlight_mask, m9);
        else n_pass++;
        blank();
        n_tot++;
        if (highlight_mask !== '0) $display("FAIL hl_reclear got %h exp 0", highlight_mask);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_boundary();
        test_wrap();
        test_reset_mid();
        test_highlight();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
